// File: rtl/cache_victim_buffer_pkg.sv
// Shared parameters, write-type codes and the buffered entry payload.
package cache_victim_buffer_pkg;

    localparam int unsigned DEPTH     = 2;
    localparam int unsigned MAX_INFLT = 3;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LINE_W    = 128;
    localparam int unsigned OFFLEN    = 4;

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned INFLT_W = $clog2(MAX_INFLT + 1);

    localparam logic [2:0] WR_TYPE_LINE = 3'b100;
    localparam logic [2:0] WR_TYPE_WORD = 3'b010;

    typedef struct packed {
        logic              uncache;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        strb;
        logic [LINE_W-1:0] data;
    } vbuf_entry_t;

    // Line number of a byte address (offset bits dropped).
    function automatic logic [ADDR_W-OFFLEN-1:0] line_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFLEN];
    endfunction

endpackage

// File: rtl/cache_victim_buffer_if.sv
// Push, bridge-write and hazard-query signals of the victim buffer.
interface cache_victim_buffer_if
    import cache_victim_buffer_pkg::*;
();
    logic              push_valid;
    logic              push_ready;
    logic              push_uncache;
    logic [ADDR_W-1:0] push_addr;
    logic [3:0]        push_wstrb;
    logic [LINE_W-1:0] push_data;

    logic              wr_req;
    logic [2:0]        wr_type;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_wstrb;
    logic [LINE_W-1:0] wr_data;
    logic              wr_rdy;
    logic              wr_ack;

    logic [ADDR_W-1:0] query_addr;
    logic              query_hit;
    logic              empty;
    logic              ack_err;

    modport slave (
        input  push_valid, push_uncache, push_addr, push_wstrb, push_data,
        input  wr_rdy, wr_ack, query_addr,
        output push_ready, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output query_hit, empty, ack_err
    );

    modport master (
        output push_valid, push_uncache, push_addr, push_wstrb, push_data,
        output wr_rdy, wr_ack, query_addr,
        input  push_ready, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  query_hit, empty, ack_err
    );
endinterface

// File: rtl/cache_vbuf_fifo.sv
// Circular entry store with head/tail/count and per-entry line match.
module cache_vbuf_fifo
    import cache_victim_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  vbuf_entry_t       push_entry,
    input  logic [ADDR_W-1:0] query_addr,
    output vbuf_entry_t       head_entry,
    output logic [CNT_W-1:0]  count,
    output logic [DEPTH-1:0]  match
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [3:0]        strb_q [DEPTH];
    logic [DEPTH-1:0]  uncache_q;
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    // Pointers, occupancy and valid bits; push and pop never target the same slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail          <= tail + PTR_W'(1);
                valid_q[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + PTR_W'(1);
                valid_q[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage, written at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail]    <= push_entry.addr;
            data_q[tail]    <= push_entry.data;
            strb_q[tail]    <= push_entry.strb;
            uncache_q[tail] <= push_entry.uncache;
        end
    end

    // Head entry read straight from the storage registers.
    always_comb begin
        head_entry.uncache = uncache_q[head];
        head_entry.addr    = addr_q[head];
        head_entry.strb    = strb_q[head];
        head_entry.data    = data_q[head];
    end

    // Line-granular compare of each valid entry against the miss address.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (line_of(addr_q[i]) == line_of(query_addr));
        end
    end

endmodule

// File: rtl/cache_victim_buffer.sv
// Write-back buffer between cache replace path and memory bridge.
module cache_victim_buffer
    import cache_victim_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    cache_victim_buffer_if.slave  bus
);
    logic               push_take;
    logic               wr_fire;
    logic               ack_ok;
    logic               ack_err;
    logic [CNT_W-1:0]   count;
    logic [INFLT_W-1:0] inflight;
    logic [DEPTH-1:0]   match;
    vbuf_entry_t        push_entry;
    vbuf_entry_t        head_entry;

    // Normalise the pushed entry: lines are aligned and fully strobed.
    always_comb begin
        push_entry.uncache = bus.push_uncache;
        push_entry.addr    = bus.push_uncache ? bus.push_addr
                                              : {bus.push_addr[ADDR_W-1:OFFLEN], OFFLEN'(0)};
        push_entry.strb    = bus.push_uncache ? bus.push_wstrb : 4'hf;
        push_entry.data    = bus.push_data;
    end

    // Handshake qualifiers; a full buffer never takes a push, even alongside a pop.
    always_comb begin
        bus.push_ready = count < CNT_W'(DEPTH);
        push_take      = bus.push_valid && bus.push_ready;
        bus.wr_req     = (count != '0) && (inflight < INFLT_W'(MAX_INFLT));
        wr_fire        = bus.wr_req && bus.wr_rdy;
        ack_ok         = bus.wr_ack && (inflight != '0);
    end

    cache_vbuf_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_take),
        .pop        (wr_fire),
        .push_entry (push_entry),
        .query_addr (bus.query_addr),
        .head_entry (head_entry),
        .count      (count),
        .match      (match)
    );

    // Outstanding-write counter and sticky error for acks with nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            ack_err  <= 1'b0;
        end else begin
            case ({wr_fire, ack_ok})
                2'b10:   inflight <= inflight + INFLT_W'(1);
                2'b01:   inflight <= inflight - INFLT_W'(1);
                default: inflight <= inflight;
            endcase
            if (bus.wr_ack && (inflight == '0)) begin
                ack_err <= 1'b1;
            end
        end
    end

    // Bridge-side formatting and status; in-flight writes count as a conservative hit.
    always_comb begin
        bus.wr_type   = head_entry.uncache ? WR_TYPE_WORD : WR_TYPE_LINE;
        bus.wr_addr   = head_entry.addr;
        bus.wr_wstrb  = head_entry.strb;
        bus.wr_data   = head_entry.data;
        bus.query_hit = (|match) || (inflight != '0);
        bus.empty     = (count == '0) && (inflight == '0);
        bus.ack_err   = ack_err;
    end

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Scoreboard bench: driver queues expected writes, monitor checks bridge side each cycle.
module tb_cache_victim_buffer;
    import cache_victim_buffer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_victim_buffer_if bus ();

    cache_victim_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          uncache;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];      // accepted, not yet handed to the bridge, oldest first
    int   inflight_m = 0;
    bit   ack_err_m  = 1'b0;
    bit   new_push   = 1'b0;  // back of exp_q was issued this cycle, not yet stored
    bit   go         = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; the expected write is queued when the model says it is taken.
    task automatic cyc(input bit pv, input bit unc, input logic [31:0] a, input logic [3:0] s,
                       input logic [127:0] d, input bit rdy, input bit ack,
                       input logic [31:0] q, input bit rst);
        exp_t e;
        reset            = rst;
        bus.push_valid   = pv;
        bus.push_uncache = unc;
        bus.push_addr    = a;
        bus.push_wstrb   = s;
        bus.push_data    = d;
        bus.wr_rdy       = rdy;
        bus.wr_ack       = ack;
        bus.query_addr   = q;
        if (pv && !rst && exp_q.size() < DEPTH) begin
            e.uncache = unc;
            e.addr    = unc ? a : {a[31:4], 4'h0};
            e.strb    = unc ? s : 4'hf;
            e.data    = d;
            exp_q.push_back(e);
            new_push = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input bit ack, input logic [31:0] q);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, rdy, ack, q, 1'b0);
    endtask

    task automatic line(input logic [31:0] a, input logic [127:0] d, input bit rdy,
                        input bit ack, input logic [31:0] q);
        cyc(1'b1, 1'b0, a, 4'h0, d, rdy, ack, q, 1'b0);
    endtask

    // Monitor: compare outputs mid-cycle, then advance the model across the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (go) begin
                int   cnt;
                bit   req_exp;
                bit   hit_exp;
                bit   fire;
                bit   ack_ok;
                exp_t h;
                cnt     = exp_q.size() - int'(new_push);
                req_exp = (cnt != 0) && (inflight_m < MAX_INFLT);
                hit_exp = (inflight_m != 0);
                for (int i = 0; i < cnt; i++) begin
                    if (exp_q[i].addr[31:4] == bus.query_addr[31:4]) hit_exp = 1'b1;
                end
                chk("push_ready", bus.push_ready, cnt < DEPTH);
                chk("wr_req", bus.wr_req, req_exp);
                chk("empty", bus.empty, (cnt == 0) && (inflight_m == 0));
                chk("query_hit", bus.query_hit, hit_exp);
                chk("ack_err", bus.ack_err, ack_err_m);
                if (req_exp) begin
                    h = exp_q[0];
                    chk("wr_type", bus.wr_type, h.uncache ? 3'b010 : 3'b100);
                    chk("wr_addr", bus.wr_addr, h.addr);
                    chk("wr_wstrb", bus.wr_wstrb, h.strb);
                    if (h.uncache) chk("wr_data_word", bus.wr_data[31:0], h.data[31:0]);
                    else           chk("wr_data_line", bus.wr_data, h.data);
                end
                if (reset) begin
                    exp_q.delete();
                    inflight_m = 0;
                    ack_err_m  = 1'b0;
                end else begin
                    fire   = req_exp && bus.wr_rdy;
                    ack_ok = bus.wr_ack && (inflight_m != 0);
                    if (bus.wr_ack && inflight_m == 0) ack_err_m = 1'b1;
                    if (fire) void'(exp_q.pop_front());
                    inflight_m = inflight_m + int'(fire) - int'(ack_ok);
                end
                new_push = 1'b0;
            end
        end
    end

    initial begin
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(1'b0, 1'b0, 32'h0);
        go = 1'b1;
        idle(1'b0, 1'b0, 32'h0);

        // Single line writeback, aligned address, empty until acked.
        line(32'hc000_1234, {16{8'haa}}, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b0, 32'h0);

        // Fill with bridge stalled, third push refused, then drain in order.
        line(32'h0000_1000, {4{32'h1111_0000}}, 1'b0, 1'b0, 32'h0);
        line(32'h0000_2000, {4{32'h2222_0000}}, 1'b0, 1'b0, 32'h0);
        line(32'h0000_3000, {4{32'h3333_0000}}, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        // Full with a pop this cycle: push refused, retried and taken next cycle.
        line(32'h0000_4000, {4{32'h4444_0000}}, 1'b1, 1'b0, 32'h0);
        line(32'h0000_4000, {4{32'h4444_0000}}, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b0, 32'h0);

        // Uncached word store keeps full address and strobe.
        cyc(1'b1, 1'b1, 32'h8000_0006, 4'b1100, {96'h0, 32'hdead_beef}, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b0, 32'h0);

        // Hazard query: pending entry, then in-flight, then clear after ack.
        line(32'h0000_0100, {4{32'h0100_0100}}, 1'b0, 1'b0, 32'h0000_010c);
        idle(1'b0, 1'b0, 32'h0000_010c);
        idle(1'b0, 1'b0, 32'h0000_0110);
        idle(1'b1, 1'b0, 32'h0000_0110);
        idle(1'b0, 1'b0, 32'h0000_0110);
        idle(1'b0, 1'b1, 32'h0000_0110);
        idle(1'b0, 1'b0, 32'h0000_0110);

        // In-flight limit: three writes unacked stall the fourth until one ack.
        for (int i = 0; i < 4; i++) line(32'h0001_0000 + 32'(i * 16), {4{32'(i)}}, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1, 32'h0);
        // Spurious ack, then reset clears the sticky error.
        idle(1'b1, 1'b1, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(1'b0, 1'b0, 32'h0);

        // Randomized traffic over a small address pool so line hazards recur.
        for (int k = 0; k < 3000; k++) begin
            logic [31:0]  a;
            logic [31:0]  q;
            logic [127:0] d;
            bit           rst;
            bit           ack;
            a   = {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 20'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
            q   = {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 20'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
            d   = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(0, 399) == 0);
            ack = ((inflight_m > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 299) == 0);
            cyc(!rst && ($urandom_range(0, 1) != 0), ($urandom_range(0, 2) == 0), a, 4'($urandom), d,
                ($urandom_range(0, 2) != 0), ack, q, rst);
        end
        idle(1'b0, 1'b0, 32'h0);
        go = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
